// File: rtl/stage1_if_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   RESET_PC_DEF : default first fetch address after reset
//   NOP_INST_DEF : bubble word (sll $0,$0,0)
//   if_state_t   : fetch FSM state encoding
package stage1_if_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding at pc
    DRAIN = 2'd1,  // redirected while a request was pending; finish and drop it
    HOLD  = 2'd2   // word parked in skid buffer while decode is stalled
  } if_state_t;

endpackage

// File: rtl/stage1_if_skid.sv
// One-entry skid buffer for the fetch stage (if_skid).
// Parks a fetched word and its PC+4 while decode is stalled.
//   clk, rst_n      : clock, asynchronous active-low reset (clears full flag)
//   load            : capture word_in/pc4_in, mark full
//   clear           : mark empty (load wins if both asserted)
//   word_in, pc4_in : data to park
//   full            : buffer holds a valid entry
//   word, pc4       : parked entry
module stage1_if_skid
  import stage1_if_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] word_in,
  input  logic [31:0] pc4_in,
  output logic        full,
  output logic [31:0] word,
  output logic [31:0] pc4
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed while full is set.
  always_ff @(posedge clk) begin
    if (load) begin
      word <= word_in;
      pc4  <= pc4_in;
    end
  end

endmodule

// File: rtl/stage1_if.sv
// Instruction-fetch stage with IF/ID pipeline register.
//   clk, rst_n           : clock, asynchronous active-low reset
//   stall                : hold IF/ID outputs this cycle
//   branch_taken/target  : redirect fetch, flush IF/ID
//   imem_req/addr        : registered instruction memory request
//   imem_ready/rdata     : memory handshake, data returned same cycle
//   inst, pc4_out        : registered instruction and its PC+4
//   inst_valid           : 0 when inst is a bubble
module stage1_if
  import stage1_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc4_out,
  output logic        inst_valid
);

  if_state_t   state, state_n;
  logic [31:0] pc, pc_n, addr_n, inst_n, pc4_n;
  logic        valid_n, req_n;
  logic        skid_load, skid_clear, skid_full;
  logic [31:0] skid_word, skid_pc4;
  logic [31:0] pc_plus4, target;
  logic        xfer;

  assign pc_plus4 = pc + 32'd4;
  assign target   = {branch_target[31:2], 2'b00};
  // A transfer only exists when our own registered request is up.
  assign xfer     = imem_req & imem_ready;

  stage1_if_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .clear   (skid_clear),
    .word_in (imem_rdata),
    .pc4_in  (pc_plus4),
    .full    (skid_full),
    .word    (skid_word),
    .pc4     (skid_pc4)
  );

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    addr_n     = imem_addr;
    inst_n     = inst;
    pc4_n      = pc4_out;
    valid_n    = inst_valid;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    case (state)
      FETCH: begin
        if (branch_taken) begin
          inst_n  = NOP_INST;
          valid_n = 1'b0;
          pc_n    = target;
          // A pending request must complete at its original address.
          if (imem_req && !imem_ready) state_n = DRAIN;
          else                         addr_n  = target;
        end else if (xfer) begin
          pc_n   = pc_plus4;
          addr_n = pc_plus4;
          if (stall) begin
            skid_load = 1'b1;
            state_n   = HOLD;
          end else begin
            inst_n  = imem_rdata;
            pc4_n   = pc_plus4;
            valid_n = 1'b1;
          end
        end else if (!stall) begin
          inst_n  = NOP_INST;
          valid_n = 1'b0;
        end
      end
      DRAIN: begin
        if (branch_taken) begin
          inst_n  = NOP_INST;
          valid_n = 1'b0;
          pc_n    = target;
        end else if (!stall) begin
          inst_n  = NOP_INST;
          valid_n = 1'b0;
        end
        // Stale word is dropped; restart at the newest redirect address.
        if (xfer) begin
          state_n = FETCH;
          addr_n  = branch_taken ? target : pc;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          inst_n     = NOP_INST;
          valid_n    = 1'b0;
          pc_n       = target;
          addr_n     = target;
          skid_clear = 1'b1;
          state_n    = FETCH;
        end else if (!stall && skid_full) begin
          inst_n     = skid_word;
          pc4_n      = skid_pc4;
          valid_n    = 1'b1;
          addr_n     = pc;
          skid_clear = 1'b1;
          state_n    = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
    req_n = (state_n != HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      imem_addr  <= RESET_PC;
      imem_req   <= 1'b0;
      inst       <= NOP_INST;
      pc4_out    <= 32'd0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      imem_addr  <= addr_n;
      imem_req   <= req_n;
      inst       <= inst_n;
      pc4_out    <= pc4_n;
      inst_valid <= valid_n;
    end
  end

endmodule
